raster_scan_gen: RTL and testbench

Raster-scan pixel sequencer for the template-matching datapath. Runs on the 100 MHz system clock (10 ns period in functional simulation) and is the first clocked stage fed by the clock source. On a start command it walks every pixel of an IMG_W x IMG_H frame in row-major order. Each beat carries the pixel coordinates, a linear address, frame and line markers, and a flag marking whether a complete TPL_W x TPL_H template window ends at that pixel. Beats are emitted over a valid/ready handshake to the image fetch and correlation stages.

---
 rtl/scan_pkg.sv | 26 ++
 rtl/wrap_counter.sv | 39 +++
 rtl/raster_scan_gen.sv | 135 +++++++++++++
 tb/tb_raster_scan_gen.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scan_pkg.sv
// rtl/scan_pkg.sv - shared state encoding, default dimensions and width helpers
package scan_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } scan_state_e;

  localparam int DEF_IMG_W   = 64;
  localparam int DEF_IMG_H   = 48;
  localparam int DEF_TPL_W   = 8;
  localparam int DEF_TPL_H   = 8;
  localparam int DEF_COORD_W = 8;
  localparam int DEF_ADDR_W  = 12;

  // Minimum widths able to hold every coordinate / linear address of the frame.
  function automatic int coord_bits(input int w, input int h);
    return $clog2((w > h) ? w : h);
  endfunction

  function automatic int addr_bits(input int w, input int h);
    return $clog2(w * h);
  endfunction

endpackage

// File: rtl/wrap_counter.sv
// rtl/wrap_counter.sv - modulo (MAX+1) counter with sync clear and terminal-count flag
module wrap_counter #(
  parameter int W   = 8,
  parameter int MAX = 63
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         tc
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == MAX_V) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;
  assign tc  = (cnt_q == MAX_V);

endmodule

// File: rtl/raster_scan_gen.sv
// rtl/raster_scan_gen.sv - row-major pixel sequencer with window flag; RASTER_ADDR_EN builds pix_addr
module raster_scan_gen
  import scan_pkg::*;
#(
  parameter int IMG_W   = DEF_IMG_W,
  parameter int IMG_H   = DEF_IMG_H,
  parameter int TPL_W   = DEF_TPL_W,
  parameter int TPL_H   = DEF_TPL_H,
  parameter int COORD_W = DEF_COORD_W,
  parameter int ADDR_W  = DEF_ADDR_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic               ready,
  output logic               valid,
  output logic [COORD_W-1:0] pix_x,
  output logic [COORD_W-1:0] pix_y,
  output logic [ADDR_W-1:0]  pix_addr,
  output logic               sof,
  output logic               eol,
  output logic               eof,
  output logic               win_valid,
  output logic               busy,
  output logic               done
);

  if (COORD_W < coord_bits(IMG_W, IMG_H)) begin : g_coord_chk
    $error("COORD_W too narrow for frame dimensions");
  end
  if (ADDR_W < addr_bits(IMG_W, IMG_H)) begin : g_addr_chk
    $error("ADDR_W too narrow for frame size");
  end

  localparam logic [COORD_W-1:0] WIN_X_MIN = COORD_W'(TPL_W - 1);
  localparam logic [COORD_W-1:0] WIN_Y_MIN = COORD_W'(TPL_H - 1);

  scan_state_e state_q;
  scan_state_e state_d;

  logic               in_scan;
  logic               xfer;
  logic               scan_start;
  logic               x_tc;
  logic               y_tc;
  logic [COORD_W-1:0] x_cnt;
  logic [COORD_W-1:0] y_cnt;

  assign in_scan    = (state_q == SCAN);
  assign xfer       = in_scan && ready;
  assign scan_start = (state_q == IDLE) && start && !abort;

  // Counters may step on an aborted beat; the clear on the next start makes that harmless.
  wrap_counter #(.W(COORD_W), .MAX(IMG_W - 1)) u_x_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (scan_start),
    .en    (xfer),
    .cnt   (x_cnt),
    .tc    (x_tc)
  );

  wrap_counter #(.W(COORD_W), .MAX(IMG_H - 1)) u_y_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (scan_start),
    .en    (xfer && x_tc),
    .cnt   (y_cnt),
    .tc    (y_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start && !abort) state_d = SCAN;
      SCAN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (xfer && x_tc && y_tc) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    valid     = in_scan;
    busy      = in_scan;
    done      = (state_q == DONE);
    pix_x     = x_cnt;
    pix_y     = y_cnt;
    sof       = in_scan && (x_cnt == '0) && (y_cnt == '0);
    eol       = in_scan && x_tc;
    eof       = in_scan && x_tc && y_tc;
    win_valid = in_scan && (x_cnt >= WIN_X_MIN) && (y_cnt >= WIN_Y_MIN);
  end

`ifdef RASTER_ADDR_EN
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_d;

  always_comb begin
    addr_d = addr_q;
    if (scan_start) begin
      addr_d = '0;
    end else if (xfer) begin
      addr_d = addr_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

  assign pix_addr = addr_q;
`else
  assign pix_addr = '0;
`endif

endmodule

// File: tb/tb_raster_scan_gen.sv
// tb/tb_raster_scan_gen.sv - scoreboard bench for raster_scan_gen on a 4x3 frame with 2x2 template
module tb_raster_scan_gen;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int TW = 2;
  localparam int TH = 2;
  localparam int CW = 8;
  localparam int AW = 12;

  typedef struct {
    int x;
    int y;
    int addr;
    bit sof;
    bit eol;
    bit eof;
    bit win;
  } beat_t;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          abort;
  logic          ready;
  logic          valid;
  logic [CW-1:0] pix_x;
  logic [CW-1:0] pix_y;
  logic [AW-1:0] pix_addr;
  logic          sof;
  logic          eol;
  logic          eof;
  logic          win_valid;
  logic          busy;
  logic          done;

  raster_scan_gen #(
    .IMG_W(W), .IMG_H(H), .TPL_W(TW), .TPL_H(TH), .COORD_W(CW), .ADDR_W(AW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .ready     (ready),
    .valid     (valid),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .pix_addr  (pix_addr),
    .sof       (sof),
    .eol       (eol),
    .eof       (eof),
    .win_valid (win_valid),
    .busy      (busy),
    .done      (done)
  );

  beat_t exp_q[$];
  int    n_vec;
  int    n_err;
  int    ready_mode;
  int    win_cnt;
  bit    exp_done;
  bit    stalled;
  int    held_x;
  int    held_y;
  int    held_a;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference frame: every pixel in row-major order, fields from their definitions.
  task automatic push_frame();
    beat_t b;
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        b.x = x;
        b.y = y;
`ifdef RASTER_ADDR_EN
        b.addr = y * W + x;
`else
        b.addr = 0;
`endif
        b.sof = (x == 0) && (y == 0);
        b.eol = (x == W - 1);
        b.eof = (x == W - 1) && (y == H - 1);
        b.win = (x >= TW - 1) && (y >= TH - 1);
        exp_q.push_back(b);
      end
    end
  endtask

  initial begin
    ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      ready = (ready_mode == 0) ? 1'b1 : ($urandom_range(0, 2) == 0);
    end
  end

  always @(negedge clk) begin
    beat_t b;
    if (!rst_n) begin
      exp_done = 1'b0;
      stalled  = 1'b0;
    end else begin
      if (exp_done) begin
        chk("done_pulse", int'(done), 1);
        chk("done_valid_low", int'(valid), 0);
        chk("done_busy_low", int'(busy), 0);
        exp_done = 1'b0;
      end else begin
        chk("no_stray_done", int'(done), 0);
      end
      if (!valid) begin
        chk("markers_gated", int'({sof, eol, eof, win_valid}), 0);
      end
      if (stalled) begin
        chk("stall_valid", int'(valid), 1);
        chk("stall_x", int'(pix_x), held_x);
        chk("stall_y", int'(pix_y), held_y);
        chk("stall_addr", int'(pix_addr), held_a);
      end
      if (valid && ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 1, 0);
        end else begin
          b = exp_q.pop_front();
          chk("beat_x", int'(pix_x), b.x);
          chk("beat_y", int'(pix_y), b.y);
          chk("beat_addr", int'(pix_addr), b.addr);
          chk("beat_sof", int'(sof), int'(b.sof));
          chk("beat_eol", int'(eol), int'(b.eol));
          chk("beat_eof", int'(eof), int'(b.eof));
          chk("beat_win", int'(win_valid), int'(b.win));
          chk("beat_busy", int'(busy), 1);
          if (b.win) win_cnt++;
          if (b.eof) exp_done = 1'b1;
        end
      end
      stalled = valid && !ready;
      held_x  = int'(pix_x);
      held_y  = int'(pix_y);
      held_a  = int'(pix_addr);
    end
  end

  task automatic start_frame();
    @(posedge clk);
    #1;
    start = 1'b1;
    push_frame();
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("start_latency_valid", int'(valid), 1);
    chk("start_x0", int'(pix_x), 0);
    chk("start_y0", int'(pix_y), 0);
    chk("start_addr0", int'(pix_addr), 0);
    chk("start_sof", int'(sof), 1);
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 1000 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (done) seen = 1'b1;
    end
    chk("done_timeout", int'(seen), 1);
  endtask

  task automatic wait_beat(input int x, input int y);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 1000 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (valid && int'(pix_x) == x && int'(pix_y) == y) seen = 1'b1;
    end
    chk("beat_wait_timeout", int'(seen), 1);
  endtask

  initial begin
    n_vec      = 0;
    n_err      = 0;
    ready_mode = 0;
    win_cnt    = 0;
    exp_done   = 1'b0;
    stalled    = 1'b0;
    start      = 1'b0;
    abort      = 1'b0;
    rst_n      = 1'b0;
    #3;
    chk("rst_valid", int'(valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_x", int'(pix_x), 0);
    chk("rst_addr", int'(pix_addr), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Full frame at full throughput.
    start_frame();
    wait_done();
    chk("frame1_drained", exp_q.size(), 0);
    chk("frame1_win_count", win_cnt, (W - TW + 1) * (H - TH + 1));
    repeat (2) @(posedge clk);

    // Backpressure with a start pulse mid-scan that must be ignored.
    ready_mode = 1;
    start_frame();
    repeat (7) @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done();
    chk("bp_drained", exp_q.size(), 0);
    ready_mode = 0;
    repeat (2) @(posedge clk);

    // Abort coincident with the transfer of beat (1,1).
    start_frame();
    wait_beat(1, 1);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    chk("abort_remaining", exp_q.size(), W * H - (W + 2));
    exp_q.delete();
    @(negedge clk);
    chk("abort_valid", int'(valid), 0);
    chk("abort_busy", int'(busy), 0);
    repeat (4) @(posedge clk);

    // Back-to-back frames: restart in the first IDLE cycle after done.
    start_frame();
    wait_done();
    @(posedge clk);
    #1;
    start = 1'b1;
    push_frame();
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("b2b_valid", int'(valid), 1);
    chk("b2b_x0", int'(pix_x), 0);
    chk("b2b_y0", int'(pix_y), 0);
    chk("b2b_addr0", int'(pix_addr), 0);
    wait_done();
    chk("b2b_drained", exp_q.size(), 0);
    repeat (2) @(posedge clk);

    // Asynchronous reset in the middle of a scan.
    start_frame();
    wait_beat(2, 1);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("arst_valid", int'(valid), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_x", int'(pix_x), 0);
    chk("arst_y", int'(pix_y), 0);
    chk("arst_addr", int'(pix_addr), 0);
    chk("arst_markers", int'({sof, eol, eof, win_valid, done}), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    start_frame();
    wait_done();
    chk("post_rst_drained", exp_q.size(), 0);
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
